generador_inmediato_seg: RTL and testbench

- Registered, handshaked RV32I/RV64I immediate generator for the pipelined datapath, placed between the fetch/decode register and the execute stage.
- Decodes every base format (R, I, S, B, U, J), sign-extends to XLEN and reports the detected format.
- Buffers results in a 2-entry skid stage, so backpressure from execute never drops or duplicates an instruction.
- Flags and counts unsupported opcodes.

---
 rtl/gen_inmediato_pkg.sv | 36 +++
 rtl/generador_inmediato_seg_if.sv | 28 ++
 rtl/decodificador_inmediato.sv | 69 ++++++
 rtl/generador_inmediato_seg.sv | 89 ++++++++
 tb/tb_generador_inmediato_seg.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/gen_inmediato_pkg.sv
// Shared opcode constants, format codes and buffer states for the immediate generator.
// Optional RV64 word opcodes are enabled with GEN_INMEDIATO_RV64W_EN.
package gen_inmediato_pkg;

  localparam int TIPO_W = 3;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;

  typedef enum logic [TIPO_W-1:0] {
    TIPO_R      = 3'd0,
    TIPO_I      = 3'd1,
    TIPO_S      = 3'd2,
    TIPO_B      = 3'd3,
    TIPO_U      = 3'd4,
    TIPO_J      = 3'd5,
    TIPO_ILEGAL = 3'd7
  } tipo_t;

  typedef enum logic [1:0] {
    VACIO = 2'd0,
    UNO   = 2'd1,
    LLENO = 2'd2
  } estado_t;

endpackage

// File: rtl/generador_inmediato_seg_if.sv
// Handshake bundle between decode register, immediate generator and execute stage.
// slave = the generator itself, master = the surrounding pipeline.
interface generador_inmediato_seg_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
);
  import gen_inmediato_pkg::*;

  logic [31:0]       instruccion_i;
  logic              valido_i;
  logic              listo_o;
  logic [XLEN-1:0]   inmediato_o;
  logic [TIPO_W-1:0] tipo_o;
  logic              ilegal_o;
  logic              valido_o;
  logic              listo_i;
  logic [CNT_W-1:0]  cuenta_ilegal_o;

  modport slave (
    input  instruccion_i, valido_i, listo_i,
    output listo_o, inmediato_o, tipo_o, ilegal_o, valido_o, cuenta_ilegal_o
  );

  modport master (
    output instruccion_i, valido_i, listo_i,
    input  listo_o, inmediato_o, tipo_o, ilegal_o, valido_o, cuenta_ilegal_o
  );
endinterface

// File: rtl/decodificador_inmediato.sv
// Combinational RV32I/RV64I immediate decode: format, sign-extended immediate, illegal flag.
// OP-IMM-32/OP-32 decode only when GEN_INMEDIATO_RV64W_EN is defined and XLEN is 64.
module decodificador_inmediato
  import gen_inmediato_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruccion,
  output logic [XLEN-1:0] inmediato,
  output tipo_t           tipo,
  output logic            ilegal
);

`ifdef GEN_INMEDIATO_RV64W_EN
  localparam bit RV64W = (XLEN == 64);
`else
  localparam bit RV64W = 1'b0;
`endif

  logic [6:0]  opcode;
  logic [31:0] imm32;

  assign opcode = instruccion[6:0];

  always_comb begin
    imm32  = '0;
    tipo   = TIPO_ILEGAL;
    ilegal = 1'b0;
    case (opcode)
      OP_R: tipo = TIPO_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        tipo  = TIPO_I;
        imm32 = {{20{instruccion[31]}}, instruccion[31:20]};
      end
      OP_STORE: begin
        tipo  = TIPO_S;
        imm32 = {{20{instruccion[31]}}, instruccion[31:25], instruccion[11:7]};
      end
      OP_BRANCH: begin
        tipo  = TIPO_B;
        imm32 = {{19{instruccion[31]}}, instruccion[31], instruccion[7],
                 instruccion[30:25], instruccion[11:8], 1'b0};
      end
      OP_JAL: begin
        tipo  = TIPO_J;
        imm32 = {{11{instruccion[31]}}, instruccion[31], instruccion[19:12],
                 instruccion[20], instruccion[30:21], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        tipo  = TIPO_U;
        imm32 = {instruccion[31:12], 12'b0};
      end
      default: begin
        if (RV64W && opcode == OP_IMM_32) begin
          tipo  = TIPO_I;
          imm32 = {{20{instruccion[31]}}, instruccion[31:20]};
        end else if (RV64W && opcode == OP_32) begin
          tipo = TIPO_R;
        end else begin
          ilegal = 1'b1;
        end
      end
    endcase
  end

  // Every format's sign bit is imm32[31], so widening just replicates it.
  assign inmediato = {{(XLEN - 31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/generador_inmediato_seg.sv
// Registered immediate generator with 2-entry skid buffer and saturating illegal-opcode counter.
// 1-cycle latency when empty; listo_o is registered (not LLENO), outputs hold while stalled.
module generador_inmediato_seg
  import gen_inmediato_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  generador_inmediato_seg_if.slave   bus
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    tipo_t           tipo;
    logic            ilegal;
  } entrada_t;

  entrada_t         nueva, ent_a, ent_b;
  estado_t          estado, estado_sig;
  logic             listo, valido;
  logic             entra, sale;
  logic [CNT_W-1:0] cuenta;

  decodificador_inmediato #(.XLEN(XLEN)) u_dec (
    .instruccion (bus.instruccion_i),
    .inmediato   (nueva.imm),
    .tipo        (nueva.tipo),
    .ilegal      (nueva.ilegal)
  );

  assign entra = bus.valido_i & listo;
  assign sale  = valido & bus.listo_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) estado <= VACIO;
    else       estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      VACIO:   if (entra) estado_sig = UNO;
      UNO: begin
        if (entra && !sale)      estado_sig = LLENO;
        else if (!entra && sale) estado_sig = VACIO;
      end
      LLENO:   if (sale) estado_sig = UNO;
      default: estado_sig = VACIO;
    endcase
  end

  // Both handshake outputs depend only on the state register.
  always_comb begin
    listo  = (estado != LLENO);
    valido = (estado != VACIO);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ent_a <= '0;
      ent_b <= '0;
    end else begin
      case (estado)
        VACIO: if (entra) ent_a <= nueva;
        UNO: begin
          if (entra && sale) ent_a <= nueva;
          else if (entra)    ent_b <= nueva;
        end
        LLENO: if (sale) ent_a <= ent_b;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                         cuenta <= '0;
    else if (entra && nueva.ilegal && (cuenta != '1))  cuenta <= cuenta + 1'b1;
  end

  assign bus.listo_o         = listo;
  assign bus.valido_o        = valido;
  assign bus.inmediato_o     = ent_a.imm;
  assign bus.tipo_o          = ent_a.tipo;
  assign bus.ilegal_o        = ent_a.ilegal;
  assign bus.cuenta_ilegal_o = cuenta;

endmodule

// File: tb/tb_generador_inmediato_seg.sv
// Directed bench: 32-bit/CNT_W=8 instance for decode, skid and reset; 64-bit/CNT_W=2 for
// sign extension, RV64 word opcodes and counter saturation.
module tb_generador_inmediato_seg;
  import gen_inmediato_pkg::*;

  logic clk;
  logic rst;
  int   n_total = 0;
  int   n_ok    = 0;

  generador_inmediato_seg_if #(.XLEN(32), .CNT_W(8)) bus32 ();
  generador_inmediato_seg_if #(.XLEN(64), .CNT_W(2)) bus64 ();

  generador_inmediato_seg #(.XLEN(32), .CNT_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus32)
  );

  generador_inmediato_seg #(.XLEN(64), .CNT_W(2)) dut64 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chequear(input string tag, input logic [63:0] obs, input logic [63:0] esp);
    n_total++;
    if (obs === esp) n_ok++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, esp);
  endtask

  // Advance one edge and settle; outputs are sampled 1 time unit after the edge.
  task automatic paso();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vec_inst [4];
  logic [31:0] vec_imm  [4];
  logic [2:0]  vec_tipo [4];

  initial begin
    vec_inst[0] = 32'hFE112E23; vec_imm[0] = 32'hFFFFFFFC; vec_tipo[0] = 3'd2;
    vec_inst[1] = 32'hFE000CE3; vec_imm[1] = 32'hFFFFFFF8; vec_tipo[1] = 3'd3;
    vec_inst[2] = 32'h0010006F; vec_imm[2] = 32'h00000800; vec_tipo[2] = 3'd5;
    vec_inst[3] = 32'h123450B7; vec_imm[3] = 32'h12345000; vec_tipo[3] = 3'd4;

    rst = 1'b1;
    bus32.instruccion_i = '0; bus32.valido_i = 1'b0; bus32.listo_i = 1'b1;
    bus64.instruccion_i = '0; bus64.valido_i = 1'b0; bus64.listo_i = 1'b1;
    #1;
    chequear("rst_valido", bus32.valido_o, 0);
    chequear("rst_listo", bus32.listo_o, 1);
    chequear("rst_imm", bus32.inmediato_o, 0);
    chequear("rst_tipo", bus32.tipo_o, 0);
    chequear("rst_ilegal", bus32.ilegal_o, 0);
    chequear("rst_cuenta", bus32.cuenta_ilegal_o, 0);
    #2 rst = 1'b0;

    // Single addi, one-cycle latency
    bus32.instruccion_i = 32'hFFF00093; bus32.valido_i = 1'b1;
    paso();
    chequear("addi_valido", bus32.valido_o, 1);
    chequear("addi_imm", bus32.inmediato_o, 32'hFFFFFFFF);
    chequear("addi_tipo", bus32.tipo_o, 1);
    chequear("addi_ilegal", bus32.ilegal_o, 0);

    // Back-to-back stream
    for (int i = 0; i < 4; i++) begin
      bus32.instruccion_i = vec_inst[i];
      paso();
      chequear($sformatf("b2b%0d_valido", i), bus32.valido_o, 1);
      chequear($sformatf("b2b%0d_imm", i), bus32.inmediato_o, vec_imm[i]);
      chequear($sformatf("b2b%0d_tipo", i), bus32.tipo_o, vec_tipo[i]);
    end
    bus32.valido_i = 1'b0;
    paso();
    chequear("b2b_vacio", bus32.valido_o, 0);

    // Backpressure: imm 5, 10, 15 offered while stalled
    bus32.listo_i = 1'b0; bus32.valido_i = 1'b1;
    bus32.instruccion_i = 32'h00500093;
    paso();
    chequear("bp1_listo", bus32.listo_o, 1);
    chequear("bp1_imm", bus32.inmediato_o, 5);
    bus32.instruccion_i = 32'h00A00093;
    paso();
    chequear("bp2_listo", bus32.listo_o, 0);
    chequear("bp2_imm", bus32.inmediato_o, 5);
    bus32.instruccion_i = 32'h00F00093;
    paso();
    chequear("bp3_listo", bus32.listo_o, 0);
    chequear("bp3_valido", bus32.valido_o, 1);
    chequear("bp3_imm_estable", bus32.inmediato_o, 5);
    bus32.listo_i = 1'b1;
    paso();
    chequear("bp4_imm", bus32.inmediato_o, 10);
    chequear("bp4_listo", bus32.listo_o, 1);
    paso();
    chequear("bp5_imm", bus32.inmediato_o, 15);
    bus32.valido_i = 1'b0;
    paso();
    chequear("bp6_vacio", bus32.valido_o, 0);
    chequear("bp6_listo", bus32.listo_o, 1);

    // Illegal opcodes; OP-32 stays illegal at XLEN=32 regardless of the macro
    bus32.valido_i = 1'b1;
    bus32.instruccion_i = 32'h00000000;
    paso();
    chequear("il0_ilegal", bus32.ilegal_o, 1);
    chequear("il0_tipo", bus32.tipo_o, 7);
    chequear("il0_imm", bus32.inmediato_o, 0);
    bus32.instruccion_i = 32'h0000007F;
    paso();
    chequear("il1_ilegal", bus32.ilegal_o, 1);
    chequear("il1_tipo", bus32.tipo_o, 7);
    chequear("il_cuenta2", bus32.cuenta_ilegal_o, 2);
    bus32.instruccion_i = 32'h0000003B;
    paso();
    chequear("op32_xlen32_tipo", bus32.tipo_o, 7);
    chequear("il_cuenta3", bus32.cuenta_ilegal_o, 3);
    bus32.valido_i = 1'b0;
    paso();

    // 64-bit instance
    bus64.valido_i = 1'b1;
    bus64.instruccion_i = 32'h8000006F;
    paso();
    chequear("rv64_jal_imm", bus64.inmediato_o, 64'hFFFFFFFFFFF00000);
    chequear("rv64_jal_tipo", bus64.tipo_o, 5);
    bus64.instruccion_i = 32'hFFF0009B;
    paso();
`ifdef GEN_INMEDIATO_RV64W_EN
    chequear("addiw_tipo", bus64.tipo_o, 1);
    chequear("addiw_imm", bus64.inmediato_o, 64'hFFFFFFFFFFFFFFFF);
`else
    chequear("addiw_tipo", bus64.tipo_o, 7);
    chequear("addiw_imm", bus64.inmediato_o, 0);
`endif
    bus64.instruccion_i = 32'h00000000;
    for (int i = 0; i < 5; i++) paso();
    chequear("sat_cuenta", bus64.cuenta_ilegal_o, 3);
    bus64.valido_i = 1'b0;

    // Fill to LLENO, then asynchronous reset between edges
    bus32.listo_i = 1'b0; bus32.valido_i = 1'b1;
    bus32.instruccion_i = 32'h00500093;
    paso();
    paso();
    chequear("pre_rst_listo", bus32.listo_o, 0);
    #2 rst = 1'b1;
    #1;
    chequear("arst_valido", bus32.valido_o, 0);
    chequear("arst_listo", bus32.listo_o, 1);
    chequear("arst_cuenta", bus32.cuenta_ilegal_o, 0);
    chequear("arst_cuenta64", bus64.cuenta_ilegal_o, 0);

    $display("%0d/%0d checks passed", n_ok, n_total);
    $finish;
  end

endmodule
